// File: rtl/cpmg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpmg_seq_ctrl
//
// Programmable echo-train scheduler for the NMR pulse datapath.
//
// The DSP loads an 8-entry segment table over a simple write strobe. Each entry
// holds a duration in timing ticks and a 4-bit phase code. It also loads three
// loop registers:
//   - last_idx : index of the final segment in the table.
//   - loop_idx : index where each repeat pass re-enters.
//   - echo_num : total number of passes.
//
// On start the sequencer works in two parts:
//   - Prologue: segments 0..last_idx, played once.
//   - Loop: segments loop_idx..last_idx, repeated until echo_num passes have
//     been completed.
// The active phase code drives the H-bridge and acquisition gating. A sticky
// interrupt is raised on normal completion.
//
// Parameters
//   PRESC_DIV : clk cycles per timing tick (40 -> 1 us at 40 MHz).
//   NSEG      : segment table depth (fixed at 8, 3-bit index).
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   wr_en      in   one-cycle configuration write strobe
//   wr_addr    in   [4:0] configuration address:
//                     0x00-0x07 duration[i]
//                     0x08-0x0F code[i]
//                     0x10 last_idx, 0x11 loop_idx, 0x12 echo_num
//   wr_data    in   [15:0] configuration write data
//   start      in   one-cycle run request
//   stop       in   one-cycle abort request
//   irq_clr    in   clears the sticky interrupt
//   busy       out  sequence running
//   phase_code out  [3:0] code of the active segment, 0 when idle
//   seg_idx    out  [2:0] active segment index
//   echo_cnt   out  [15:0] completed loop passes
//   seg_start  out  pulse on the first cycle of every segment
//   done       out  pulse on normal completion
//   aborted    out  pulse when a run is stopped
//   irq        out  sticky completion interrupt
// -----------------------------------------------------------------------------
module cpmg_seq_ctrl #(
   parameter int PRESC_DIV = 40,
   parameter int NSEG      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic        start,
   input  logic        stop,
   input  logic        irq_clr,
   output logic        busy,
   output logic [3:0]  phase_code,
   output logic [2:0]  seg_idx,
   output logic [15:0] echo_cnt,
   output logic        seg_start,
   output logic        done,
   output logic        aborted,
   output logic        irq
);

   // Prescaler width; kept at least one bit so PRESC_DIV = 1 still elaborates.
   localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
   localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // A zero duration still occupies one tick, so a segment is never skipped.
   function automatic logic [15:0] eff_dur(input logic [15:0] d);
      eff_dur = (d == 16'd0) ? 16'd1 : d;
   endfunction

   // A zero pass count still plays the prologue once.
   function automatic logic [15:0] eff_echo(input logic [15:0] n);
      eff_echo = (n == 16'd0) ? 16'd1 : n;
   endfunction

   // The loop re-entry point can never lie beyond the last segment.
   function automatic logic [2:0] clamp_idx(input logic [2:0] idx, input logic [2:0] lim);
      clamp_idx = (idx > lim) ? lim : idx;
   endfunction

   // Configuration registers
   logic [15:0] dur_r  [NSEG];
   logic [3:0]  code_r [NSEG];
   logic [2:0]  last_idx_r;
   logic [2:0]  loop_idx_r;
   logic [15:0] echo_num_r;

   // Sequencer state
   state_t      state_r;
   logic [PW-1:0] presc_r;
   logic [15:0] tick_r;

   // Combinational decisions
   logic [15:0] eff_dur_s;
   logic [15:0] eff_echo_s;
   logic [2:0]  eff_loop_s;
   logic        presc_wrap_s;
   logic        seg_end_s;
   logic        at_last_s;
   logic [16:0] pass_next_s;
   logic        more_pass_s;
   logic [2:0]  next_seg_s;
   logic        finish_s;
   logic        irq_set_s;

   // Segment-end detection and choice of the following segment.
   always_comb begin
      eff_dur_s    = eff_dur(dur_r[seg_idx]);
      eff_echo_s   = eff_echo(echo_num_r);
      eff_loop_s   = clamp_idx(loop_idx_r, last_idx_r);
      presc_wrap_s = (presc_r == PRESC_LAST);
      seg_end_s    = presc_wrap_s && (tick_r == (eff_dur_s - 16'd1));
      at_last_s    = (seg_idx == last_idx_r);
      // 17-bit pass arithmetic keeps the comparison exact at echo_num = 65535.
      pass_next_s  = {1'b0, echo_cnt} + 17'd1;
      more_pass_s  = (pass_next_s < {1'b0, eff_echo_s});
      if (at_last_s) begin
         next_seg_s = eff_loop_s;
      end else begin
         next_seg_s = seg_idx + 3'd1;
      end
      finish_s  = (state_r == ST_RUN) && !stop && seg_end_s && at_last_s && !more_pass_s;
      // Set is asserted both on the edge entering FINISH and on the edge
      // leaving it, so an irq_clr landing on the done cycle cannot win.
      irq_set_s = finish_s || (state_r == ST_FINISH);
   end

   // Configuration table writes: accepted only while the sequencer is idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSEG; i++) begin
            dur_r[i]  <= 16'd0;
            code_r[i] <= 4'd0;
         end
         last_idx_r <= 3'd0;
         loop_idx_r <= 3'd0;
         echo_num_r <= 16'd0;
      end else if (wr_en && (state_r == ST_IDLE)) begin
         case (wr_addr[4:3])
            2'b00: dur_r[wr_addr[2:0]]  <= wr_data;
            2'b01: code_r[wr_addr[2:0]] <= wr_data[3:0];
            2'b10: begin
               case (wr_addr[2:0])
                  3'd0:    last_idx_r <= wr_data[2:0];
                  3'd1:    loop_idx_r <= wr_data[2:0];
                  3'd2:    echo_num_r <= wr_data;
                  default: begin end
               endcase
            end
            default: begin end
         endcase
      end
   end

   // Main sequencer FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         presc_r    <= PRESC_ZERO;
         tick_r     <= 16'd0;
         busy       <= 1'b0;
         phase_code <= 4'd0;
         seg_idx    <= 3'd0;
         echo_cnt   <= 16'd0;
         seg_start  <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         seg_start <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Stop has priority over a simultaneous start.
               if (start && !stop) begin
                  state_r    <= ST_RUN;
                  busy       <= 1'b1;
                  seg_idx    <= 3'd0;
                  echo_cnt   <= 16'd0;
                  phase_code <= code_r[0];
                  seg_start  <= 1'b1;
                  presc_r    <= PRESC_ZERO;
                  tick_r     <= 16'd0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_r    <= ST_IDLE;
                  busy       <= 1'b0;
                  phase_code <= 4'd0;
                  aborted    <= 1'b1;
                  presc_r    <= PRESC_ZERO;
                  tick_r     <= 16'd0;
               end else if (seg_end_s) begin
                  // The prescaler restarts at every boundary; no carry across segments.
                  presc_r <= PRESC_ZERO;
                  tick_r  <= 16'd0;
                  if (finish_s) begin
                     state_r    <= ST_FINISH;
                     busy       <= 1'b0;
                     phase_code <= 4'd0;
                     done       <= 1'b1;
                     echo_cnt   <= eff_echo_s;
                  end else begin
                     if (at_last_s) begin
                        echo_cnt <= pass_next_s[15:0];
                     end else begin
                        echo_cnt <= echo_cnt;
                     end
                     seg_idx    <= next_seg_s;
                     phase_code <= code_r[next_seg_s];
                     seg_start  <= 1'b1;
                  end
               end else if (presc_wrap_s) begin
                  presc_r <= PRESC_ZERO;
                  tick_r  <= tick_r + 16'd1;
               end else begin
                  presc_r <= presc_r + PRESC_ONE;
               end
            end
            ST_FINISH: begin
               // seg_idx and echo_cnt hold until the next start.
               state_r <= ST_IDLE;
            end
            default: begin
               state_r    <= ST_IDLE;
               busy       <= 1'b0;
               phase_code <= 4'd0;
            end
         endcase
      end
   end

   // Sticky completion interrupt; set wins over a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else if (irq_set_s) begin
         irq <= 1'b1;
      end else if (irq_clr) begin
         irq <= 1'b0;
      end else begin
         irq <= irq;
      end
   end

endmodule

// File: tb/tb_cpmg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpmg_seq_ctrl
//
// Self-checking bench for cpmg_seq_ctrl (PRESC_DIV = 4).
//
// The reference model expands each accepted run into a complete per-cycle
// timeline (a queue of expected output records). The model then pops one
// record per clock edge. A stop flushes the timeline.
//
// DUT outputs are compared against the model on every falling edge.
// Hand-computed literals pin the directed scenarios.
// -----------------------------------------------------------------------------
module tb_cpmg_seq_ctrl;

   localparam int P = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        start;
   logic        stop;
   logic        irq_clr;
   logic        busy;
   logic [3:0]  phase_code;
   logic [2:0]  seg_idx;
   logic [15:0] echo_cnt;
   logic        seg_start;
   logic        done;
   logic        aborted;
   logic        irq;

   always #5 clk = ~clk;

   cpmg_seq_ctrl #(.PRESC_DIV(P), .NSEG(8)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .irq_clr(irq_clr), .busy(busy), .phase_code(phase_code),
      .seg_idx(seg_idx), .echo_cnt(echo_cnt), .seg_start(seg_start), .done(done),
      .aborted(aborted), .irq(irq)
   );

   typedef struct packed {
      logic        busy;
      logic [3:0]  phase;
      logic [2:0]  seg;
      logic [15:0] echo;
      logic        sstart;
      logic        done;
   } rec_t;

   // Model state
   rec_t        tl[$];
   int          m_dur [8];
   int          m_code [8];
   int          m_last, m_loop, m_echo;
   logic        e_busy, e_sstart, e_done, e_abort, e_irq;
   logic [3:0]  e_phase;
   logic [2:0]  e_seg;
   logic [15:0] e_echo;

   // Counters and observations
   int n_pass = 0;
   int n_total = 0;
   int obs_busy, obs_done;
   int obs_phase[$];
   int obs_seg[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      tl.delete();
      for (int i = 0; i < 8; i++) begin
         m_dur[i]  = 0;
         m_code[i] = 0;
      end
      m_last = 0; m_loop = 0; m_echo = 0;
      e_busy = 0; e_sstart = 0; e_done = 0; e_abort = 0; e_irq = 0;
      e_phase = 0; e_seg = 0; e_echo = 0;
   endtask

   // Whole-run expansion: prologue 0..last, then loop passes eff_loop..last.
   task automatic build_timeline();
      int ee, el, first, n;
      tl.delete();
      ee = (m_echo == 0) ? 1 : m_echo;
      el = (m_loop > m_last) ? m_last : m_loop;
      for (int p = 0; p < ee; p++) begin
         first = (p == 0) ? 0 : el;
         for (int s = first; s <= m_last; s++) begin
            n = ((m_dur[s] == 0) ? 1 : m_dur[s]) * P;
            for (int c = 0; c < n; c++)
               tl.push_back('{1'b1, 4'(m_code[s]), 3'(s), 16'(p), (c == 0), 1'b0});
         end
      end
      tl.push_back('{1'b0, 4'd0, 3'(m_last), 16'(ee), 1'b0, 1'b1});
   endtask

   task automatic apply_rec(input rec_t r);
      e_busy = r.busy; e_phase = r.phase; e_seg = r.seg;
      e_echo = r.echo; e_sstart = r.sstart; e_done = r.done;
   endtask

   task automatic apply_write();
      int a;
      a = int'(wr_addr);
      if (a < 8) m_dur[a] = int'(wr_data);
      else if (a < 16) m_code[a-8] = int'(wr_data[3:0]);
      else if (a == 16) m_last = int'(wr_data[2:0]);
      else if (a == 17) m_loop = int'(wr_data[2:0]);
      else if (a == 18) m_echo = int'(wr_data);
   endtask

   // One clock edge of the model, evaluated with the inputs seen at that edge.
   task automatic model_step();
      logic was_done;
      rec_t r;
      was_done = e_done;
      if (reset) begin
         model_reset();
         return;
      end
      e_sstart = 0; e_done = 0; e_abort = 0;
      if (e_busy) begin
         if (stop) begin
            tl.delete();
            e_busy = 0; e_phase = 0; e_abort = 1;
         end else begin
            r = tl.pop_front();
            apply_rec(r);
         end
      end else if (!was_done) begin
         if (start && !stop) begin
            build_timeline();
            r = tl.pop_front();
            apply_rec(r);
         end
         if (wr_en) apply_write();
      end
      if (e_done || was_done) e_irq = 1;
      else if (irq_clr) e_irq = 0;
   endtask

   task automatic compare_all();
      chk("busy", busy, e_busy);
      chk("phase_code", phase_code, e_phase);
      chk("seg_idx", seg_idx, e_seg);
      chk("echo_cnt", echo_cnt, e_echo);
      chk("seg_start", seg_start, e_sstart);
      chk("done", done, e_done);
      chk("aborted", aborted, e_abort);
      chk("irq", irq, e_irq);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (seg_start) begin
         obs_phase.push_back(int'(phase_code));
         obs_seg.push_back(int'(seg_idx));
      end
      if (busy) obs_busy++;
      if (done) obs_done++;
   endtask

   task automatic clear_obs();
      obs_busy = 0; obs_done = 0;
      obs_phase.delete(); obs_seg.delete();
   endtask

   task automatic cfg(input logic [4:0] a, input logic [15:0] d);
      wr_addr = a; wr_data = d; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to_idle(input int budget);
      int n;
      n = 0;
      while ((e_busy || e_done) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         n_total++;
         $display("FAIL run_timeout: budget %0d cycles expired", budget);
      end
   endtask

   task automatic chk_obs5(input string name, input bit use_seg, input int e0, e1, e2, e3, e4);
      int e [5];
      int got;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
      chk({name, "_len"}, use_seg ? obs_seg.size() : obs_phase.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (use_seg) got = (i < obs_seg.size()) ? obs_seg[i] : -1;
         else got = (i < obs_phase.size()) ? obs_phase[i] : -1;
         chk(name, got, e[i]);
      end
   endtask

   task automatic load_basic();
      cfg(5'h00, 16'd2); cfg(5'h01, 16'd3); cfg(5'h02, 16'd1);
      cfg(5'h08, 16'd1); cfg(5'h09, 16'd2); cfg(5'h0A, 16'd4);
      cfg(5'h10, 16'd2); cfg(5'h11, 16'd1); cfg(5'h12, 16'd2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 16'd0;
      start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
      model_reset();
      clear_obs();
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_busy", busy, 0); chk("rst_phase", phase_code, 0);
      chk("rst_echo", echo_cnt, 0); chk("rst_irq", irq, 0);

      // Basic run: segment order 0,1,2,1,2 for 8,12,4,12,4 cycles.
      load_basic();
      clear_obs();
      pulse_start();
      run_to_idle(200);
      chk("basic_busy_cycles", obs_busy, 40);
      chk("basic_done_count", obs_done, 1);
      chk_obs5("basic_phase_seq", 1'b0, 1, 2, 4, 2, 4);
      chk("basic_echo_cnt", echo_cnt, 2);
      chk("basic_irq", irq, 1);

      // Interrupt: clear on the done cycle loses, one cycle later it clears.
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("irq_cleared", irq, 0);
      pulse_start();
      n = 0;
      while (!e_done && n < 200) begin tick(); n++; end
      chk("irq_done_seen", done, 1);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("irq_set_wins", irq, 1);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("irq_late_clear", irq, 0);

      // Protection: write and start while busy are ignored.
      clear_obs();
      pulse_start();
      repeat (5) tick();
      cfg(5'h01, 16'd7);
      pulse_start();
      run_to_idle(200);
      chk("prot_busy_cycles", obs_busy, 40);
      clear_obs();
      pulse_start();
      run_to_idle(200);
      chk("prot_rerun_cycles", obs_busy, 40);
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("start_stop_busy", busy, 0);
      tick();
      chk("start_stop_busy2", busy, 0);

      // Abort 10 cycles into segment 1.
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      clear_obs();
      pulse_start();
      n = 0;
      while (!(e_seg == 3'd1 && e_sstart) && n < 200) begin tick(); n++; end
      repeat (9) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      chk("abort_pulse", aborted, 1);
      chk("abort_busy", busy, 0);
      chk("abort_phase", phase_code, 0);
      repeat (3) tick();
      chk("abort_no_done", obs_done, 0);
      chk("abort_irq", irq, 0);
      clear_obs();
      pulse_start();
      run_to_idle(200);
      chk("abort_rerun_cycles", obs_busy, 40);
      chk("abort_rerun_done", obs_done, 1);

      // Zero durations and zero pass count.
      cfg(5'h00, 16'd0); cfg(5'h12, 16'd0); cfg(5'h10, 16'd0); cfg(5'h11, 16'd0);
      clear_obs();
      pulse_start();
      run_to_idle(200);
      chk("zero_busy_cycles", obs_busy, 4);
      chk("zero_done_count", obs_done, 1);
      chk("zero_echo_cnt", echo_cnt, 1);

      // Loop index beyond last_idx re-enters at last_idx.
      cfg(5'h00, 16'd2); cfg(5'h10, 16'd2); cfg(5'h11, 16'd5); cfg(5'h12, 16'd3);
      clear_obs();
      pulse_start();
      run_to_idle(300);
      chk_obs5("clamp_seg_seq", 1'b1, 0, 1, 2, 2, 2);
      chk("clamp_echo_cnt", echo_cnt, 3);

      // Asynchronous reset in the middle of a segment.
      pulse_start();
      repeat (6) tick();
      #2 reset = 1'b1;
      #1;
      chk("areset_busy", busy, 0); chk("areset_phase", phase_code, 0);
      chk("areset_seg", seg_idx, 0); chk("areset_irq", irq, 0);
      tick();
      reset = 1'b0;
      clear_obs();
      pulse_start();
      run_to_idle(200);
      chk("areset_table_lost_len", obs_busy, 4);
      chk("areset_table_lost_code", (obs_phase.size() > 0) ? obs_phase[0] : -1, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         start   = ($urandom_range(0, 14) == 0);
         stop    = ($urandom_range(0, 149) == 0);
         irq_clr = ($urandom_range(0, 19) == 0);
         wr_en   = !start && ($urandom_range(0, 3) == 0);
         wr_addr = 5'($urandom_range(0, 31));
         if (wr_addr < 5'd8 || wr_addr == 5'h12) wr_data = 16'($urandom_range(0, 3));
         else wr_data = 16'($urandom);
         tick();
      end
      start = 1'b0; stop = 1'b0; irq_clr = 1'b0; wr_en = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpmg_seq_ctrl.md
Name: cpmg_seq_ctrl

Overview:
- Programmable echo-train scheduler for the NMR pulse datapath.
- The DSP loads an 8-entry segment table (duration plus 4-bit phase code) and loop registers over the xa/xd-decoded write strobe.
- On start, the block steps through a prologue once, then repeats a loop section a programmed number of times.
- It drives the phase code consumed by the H-bridge/acquisition gating and raises an interrupt on completion.

Parameters:
- PRESC_DIV, 40, clk cycles per timing tick (40 gives 1 us at 40 MHz OCX).
- NSEG, 8, segment table depth (fixed 8; index 3 bits).

Ports:
- clk  in  1  system clock (40 MHz).
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  one-cycle config write strobe.
- wr_addr  in  5  config address: 0x00-0x07 duration[i]; 0x08-0x0F code[i] (bits 3:0); 0x10 last_idx (2:0); 0x11 loop_idx (2:0); 0x12 echo_num (15:0).
- wr_data  in  16  config write data.
- start  in  1  one-cycle run request.
- stop  in  1  one-cycle abort request.
- irq_clr  in  1  clears irq.
- busy  out  1  sequence running.
- phase_code  out  4  code of the active segment; 0 when idle.
- seg_idx  out  3  active segment index.
- echo_cnt  out  16  completed loop passes.
- seg_start  out  1  one-cycle pulse on the first cycle of every segment.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on stop.
- irq  out  1  sticky completion interrupt.

Behaviour:
- Reset:
  - All outputs 0.
  - Table, last_idx, loop_idx and echo_num = 0.
  - Prescaler and tick counters = 0.
  - FSM = IDLE.
- FSM states: IDLE, RUN, FINISH.
- Config writes:
  - Accepted only in IDLE; ignored while busy.
  - Unmapped addresses are ignored.
- IDLE -> RUN when start=1 and stop=0, sampled at edge k:
  - From k+1: busy=1, seg_idx=0, echo_cnt=0, phase_code=code[0], seg_start=1 for that cycle.
- Segment length:
  - Exactly max(duration[i],1) x PRESC_DIV clk cycles.
  - The prescaler restarts at every segment boundary; there is no carry between segments.
- Segment end, idx < last_idx:
  - Next cycle moves to idx+1 with a seg_start pulse.
  - No idle gap between segments.
- Segment end, idx == last_idx:
  - Let eff_echo = max(echo_num,1) and eff_loop = min(loop_idx,last_idx).
  - If echo_cnt+1 < eff_echo: echo_cnt increments and the next segment is eff_loop.
  - Otherwise go to FINISH: echo_cnt = eff_echo.
- FINISH (one cycle):
  - busy=0, phase_code=0, done=1, irq set.
  - Returns to IDLE; seg_idx and echo_cnt hold their values until the next start.
- Stop in RUN:
  - Next cycle: busy=0, phase_code=0, aborted=1, state IDLE.
  - No done pulse, irq unchanged.
- Simultaneous events:
  - start while busy: ignored.
  - start and stop in the same cycle: stop wins, no run.
  - stop in IDLE: no effect and no aborted pulse.
  - irq set and irq_clr in the same cycle: set wins.
- Counters:
  - Tick counter is 16 bits; no wrap possible at duration max 65535.
  - echo_cnt saturates by construction (never exceeds eff_echo).
- Asynchronous reset mid-run: immediately forces all outputs to 0; the table contents are lost.
- phase_code, busy and seg_idx are registered outputs, glitch-free.

Test Plan:
- Basic run, PRESC_DIV=4: dur={2,3,1}, codes={1,2,4}, last=2, loop=1, echo=2, start at edge k.
  - Required segment order: 0(8 clk), 1(12), 2(4), 1(12), 2(4).
  - busy high k+1..k+40; done and busy fall at k+41; echo_cnt=2; irq=1.
  - phase_code sequence: 1, 2, 4, 2, 4.
- Zero-edge handling: duration[0]=0, echo_num=0, last=0.
  - Segment 0 lasts PRESC_DIV cycles.
  - Single pass, done once, echo_cnt=1.
- Clamp: loop_idx=5, last_idx=2, echo=3.
  - Loop re-enters at segment 2.
  - Segment order: 0, 1, 2, 2, 2.
- Abort: stop 10 cycles into segment 1.
  - Next cycle: aborted=1, busy=0, phase_code=0.
  - done never pulses; irq stays 0; a subsequent start runs normally from segment 0.
- Protection:
  - A write to duration[1] while busy is ignored: the segment timing is unchanged, and the readback via the next run shows the old value.
  - A start while busy is ignored.
  - start+stop in the same cycle from IDLE leaves busy=0.
- Interrupt:
  - irq_clr asserted in the same cycle as FINISH leaves irq=1.
  - irq_clr one cycle later clears it.
  - Asynchronous reset mid-segment drops all outputs within the same cycle.
